// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Word-addressed synchronous data RAM behind a valid/ready request
//             port and a one-shot response pulse, with a configurable number
//             of wait states between acceptance and response.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_was_we
);

    localparam int         c_depth    = 1 << ADDR_W;
    // Counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
    // WAIT_STATES cycles; unused when there are no wait states.
    localparam logic [3:0] c_cnt_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [c_depth];

    logic                w_accept;
    logic                w_enter_resp;
    logic [ADDR_W-1:0]   w_src_addr;
    logic                w_src_we;
    logic [DATA_W-1:0]   w_src_wdata;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);

    // With zero wait states RESP is entered on the accepting edge itself, before
    // the request is latched, so the response source is taken straight from the
    // request inputs while in IDLE and from the latched copy otherwise.
    assign w_src_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_src_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_src_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_enter_resp = (w_state_next == ST_RESP) && (r_state != ST_RESP);

    // Next-state logic for the request/wait/response sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the request at acceptance and run the wait-state countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_cnt_init;
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Stores commit on the accepting edge; reset blocks a same-edge write.
    // The array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && w_accept && req_we) begin
            r_mem[req_addr] <= req_wdata;
        end
    end

    // Capture response data on entry to RESP and hold it until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata  <= '0;
            resp_was_we <= 1'b0;
        end else if (w_enter_resp) begin
            resp_rdata  <= w_src_we ? w_src_wdata : r_mem[w_src_addr];
            resp_was_we <= w_src_we;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Directed self-checking bench for dmem_responder with zero and
//             three wait states.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;

    logic        rst0, valid0, we0, ready0, rvalid0, was_we0;
    logic [7:0]  addr0;
    logic [31:0] wdata0, rdata0;

    logic        rst3, valid3, we3, ready3, rvalid3, was_we3;
    logic [7:0]  addr3;
    logic [31:0] wdata3, rdata3;

    int checks = 0;
    int errors = 0;
    logic seen;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst0),
        .req_valid  (valid0),
        .req_we     (we0),
        .req_addr   (addr0),
        .req_wdata  (wdata0),
        .req_ready  (ready0),
        .resp_valid (rvalid0),
        .resp_rdata (rdata0),
        .resp_was_we(was_we0)
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst3),
        .req_valid  (valid3),
        .req_we     (we3),
        .req_addr   (addr3),
        .req_wdata  (wdata3),
        .req_ready  (ready3),
        .resp_valid (rvalid3),
        .resp_rdata (rdata3),
        .resp_was_we(was_we3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the zero-wait-state instance.
    task automatic txn0(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string tag);
        check({tag, "_ready_pre"}, 32'(ready0), 32'd1);
        valid0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        tick();
        valid0 = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid0), 32'd1);
        check({tag, "_ready_busy"}, 32'(ready0), 32'd0);
        check({tag, "_rdata"}, rdata0, exp);
        check({tag, "_was_we"}, 32'(was_we0), 32'(we));
        tick();
        check({tag, "_rvalid_drop"}, 32'(rvalid0), 32'd0);
        check({tag, "_ready_back"}, 32'(ready0), 32'd1);
        check({tag, "_rdata_hold"}, rdata0, exp);
    endtask

    // One complete transaction on the three-wait-state instance.
    task automatic txn3(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string tag);
        check({tag, "_ready_pre"}, 32'(ready3), 32'd1);
        valid3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wdata;
        tick();
        valid3 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check({tag, "_ready_busy"}, 32'(ready3), 32'd0);
            check({tag, "_rvalid"}, 32'(rvalid3), (j == 3) ? 32'd1 : 32'd0);
            if (j == 3) begin
                check({tag, "_rdata"}, rdata3, exp);
                check({tag, "_was_we"}, 32'(was_we3), 32'(we));
            end
            tick();
        end
        check({tag, "_rvalid_drop"}, 32'(rvalid3), 32'd0);
        check({tag, "_ready_back"}, 32'(ready3), 32'd1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        rst0 = 1'b1; valid0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 32'hDEADBEEF;
        rst3 = 1'b1; valid3 = 1'b0; we3 = 1'b0; addr3 = 8'h00; wdata3 = 32'h0;

        // Reset held two cycles with a store presented.
        tick();
        tick();
        rst0 = 1'b0; rst3 = 1'b0; valid0 = 1'b0;
        check("rst_ready0", 32'(ready0), 32'd1);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_was_we0", 32'(was_we0), 32'd0);
        check("rst_ready3", 32'(ready3), 32'd1);
        check("rst_rvalid3", 32'(rvalid3), 32'd0);

        // Store issued during reset must not have been written.
        valid0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        tick();
        valid0 = 1'b0;
        check("rst_load_rvalid", 32'(rvalid0), 32'd1);
        checks++;
        assert (rdata0 !== 32'hDEADBEEF) else begin
            errors++;
            $error("FAIL rst_no_write observed=%h expected=not DEADBEEF", rdata0);
        end
        tick();

        // Zero wait states: store then load.
        txn0(1'b1, 8'h10, 32'h12345678, 32'h12345678, "ws0_store");
        txn0(1'b0, 8'h10, 32'h0, 32'h12345678, "ws0_load");

        // Address extremes.
        txn0(1'b1, 8'hFF, 32'hAAAA0000, 32'hAAAA0000, "ext_st_ff");
        txn0(1'b1, 8'h00, 32'h5555FFFF, 32'h5555FFFF, "ext_st_00");
        txn0(1'b0, 8'hFF, 32'h0, 32'hAAAA0000, "ext_ld_ff");
        txn0(1'b0, 8'h00, 32'h0, 32'h5555FFFF, "ext_ld_00");

        // Reset wins over a same-edge accept: no write.
        txn0(1'b1, 8'h40, 32'h01010101, 32'h01010101, "prio_st");
        rst0 = 1'b1; valid0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 32'h77777777;
        tick();
        rst0 = 1'b0; valid0 = 1'b0;
        check("prio_rvalid", 32'(rvalid0), 32'd0);
        check("prio_ready", 32'(ready0), 32'd1);
        txn0(1'b0, 8'h40, 32'h0, 32'h01010101, "prio_ld");

        // Three wait states: store, then load with valid held continuously.
        txn3(1'b1, 8'h10, 32'h0BADF00D, 32'h0BADF00D, "ws3_store");
        valid3 = 1'b1; we3 = 1'b0; addr3 = 8'h10;
        tick();
        for (int j = 0; j < 4; j++) begin
            check("held_ready_busy", 32'(ready3), 32'd0);
            check("held_rvalid", 32'(rvalid3), (j == 3) ? 32'd1 : 32'd0);
            if (j == 3) begin
                check("held_rdata", rdata3, 32'h0BADF00D);
                check("held_was_we", 32'(was_we3), 32'd0);
            end
            tick();
        end
        check("held_ready_e4", 32'(ready3), 32'd1);
        check("held_rvalid_e4", 32'(rvalid3), 32'd0);
        tick();
        check("held_second_accept", 32'(ready3), 32'd0);
        check("held_rdata_hold", rdata3, 32'h0BADF00D);
        valid3 = 1'b0;
        tick();
        tick();
        tick();
        check("held_second_rvalid", 32'(rvalid3), 32'd1);
        check("held_second_rdata", rdata3, 32'h0BADF00D);
        tick();

        // Inputs change while waiting; only the accepted values matter.
        valid3 = 1'b1; we3 = 1'b1; addr3 = 8'h30; wdata3 = 32'h11111111;
        tick();
        we3 = 1'b0; addr3 = 8'h10; wdata3 = 32'hFFFFFFFF;
        tick();
        we3 = 1'b1; addr3 = 8'h10; wdata3 = 32'hFFFFFFFF;
        tick();
        tick();
        valid3 = 1'b0;
        check("chg_rvalid", 32'(rvalid3), 32'd1);
        check("chg_rdata", rdata3, 32'h11111111);
        check("chg_was_we", 32'(was_we3), 32'd1);
        tick();
        check("chg_rvalid_drop", 32'(rvalid3), 32'd0);
        check("chg_rdata_hold", rdata3, 32'h11111111);
        check("chg_was_we_hold", 32'(was_we3), 32'd1);
        txn3(1'b0, 8'h10, 32'h0, 32'h0BADF00D, "chg_ld_10");
        txn3(1'b0, 8'h30, 32'h0, 32'h11111111, "chg_ld_30");

        // Reset in the middle of WAIT after a store was accepted.
        valid3 = 1'b1; we3 = 1'b1; addr3 = 8'h20; wdata3 = 32'hCAFEF00D;
        tick();
        valid3 = 1'b0;
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check("midrst_ready", 32'(ready3), 32'd1);
        check("midrst_rvalid", 32'(rvalid3), 32'd0);
        check("midrst_rdata", rdata3, 32'd0);
        check("midrst_was_we", 32'(was_we3), 32'd0);
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            seen = seen | rvalid3;
            tick();
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        txn3(1'b0, 8'h20, 32'h0, 32'hCAFEF00D, "midrst_ld");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
